// File: rtl/seq_detector_n.sv
// Serial pattern detector: flags when the last N accepted bits equal PATTERN (Mealy + Moore flags).
// Optional saturating match counter is built only when SEQDET_MATCH_COUNT_EN is defined.
module seq_detector_n #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1101,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             en,
    output logic             mealy,
    output logic             moore,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int FW = $clog2(N);
    localparam logic [FW-1:0] FILL_FULL = FW'(N - 1);

    logic [N-2:0]  r_hist;
    logic [FW-1:0] r_fill;
    logic          r_moore;

    logic [N-1:0]  w_cand;
    logic          w_full;
    logic          w_hit;

    assign w_cand = {r_hist, x};
    // Fill gating keeps the cleared history from counting as genuine bits.
    assign w_full = (r_fill == FILL_FULL);
    assign w_hit  = en & ~reset & w_full & (w_cand == PATTERN);

    assign mealy = w_hit;
    assign moore = r_moore;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_moore <= 1'b0;
        end else if (en) begin
            r_moore <= w_hit;
            if (w_hit && !OVERLAP) begin
                r_hist <= '0;
                r_fill <= '0;
            end else begin
                r_hist <= w_cand[N-2:0];
                if (!w_full) begin
                    r_fill <= r_fill + 1'b1;
                end
            end
        end else begin
            r_moore <= 1'b0;
        end
    end

`ifdef SEQDET_MATCH_COUNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_hit && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign match_cnt = r_cnt;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_n.sv
// Directed self-checking bench for seq_detector_n: four instances cover overlap,
// non-overlap, all-zero pattern fill gating and counter saturation.
module tb_seq_detector_n;

`ifdef SEQDET_MATCH_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       x = 1'b0;
    logic       en = 1'b0;
    logic       mealy_a, moore_a, mealy_b, moore_b, mealy_c, moore_c, mealy_d, moore_d;
    logic [7:0] cnt_a, cnt_b, cnt_c;
    logic [1:0] cnt_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detector_n #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .x(x), .en(en),
        .mealy(mealy_a), .moore(moore_a), .match_cnt(cnt_a));

    seq_detector_n #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) u_b (
        .clk(clk), .reset(reset), .x(x), .en(en),
        .mealy(mealy_b), .moore(moore_b), .match_cnt(cnt_b));

    seq_detector_n #(.N(4), .PATTERN(4'b0000), .OVERLAP(1'b1), .CNT_W(8)) u_c (
        .clk(clk), .reset(reset), .x(x), .en(en),
        .mealy(mealy_c), .moore(moore_c), .match_cnt(cnt_c));

    seq_detector_n #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(2)) u_d (
        .clk(clk), .reset(reset), .x(x), .en(en),
        .mealy(mealy_d), .moore(moore_d), .match_cnt(cnt_d));

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic xv, input logic ev, input logic rv);
        @(negedge clk);
        x = xv;
        en = ev;
        reset = rv;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ecnt(input int v);
        return CNT_ON ? 32'(v) : 32'd0;
    endfunction

    logic [6:0] s_ov, e_ov_a, e_ov_b;
    logic [4:0] e_zero;
    logic       prev_a, prev_b, prev_c;

    initial begin
        // Reset state
        drive(1'b0, 1'b0, 1'b1);
        chk("reset_mealy", 32'(mealy_a), 32'd0);
        drive(1'b0, 1'b0, 1'b0);
        chk("reset_moore", 32'(moore_a), 32'd0);
        chk("reset_cnt", 32'(cnt_a), 32'd0);

        // Basic match 1101
        drive(1'b1, 1'b1, 1'b0);  chk("basic_b1_mealy", 32'(mealy_a), 32'd0);
        drive(1'b1, 1'b1, 1'b0);  chk("basic_b2_mealy", 32'(mealy_a), 32'd0);
        drive(1'b0, 1'b1, 1'b0);  chk("basic_b3_mealy", 32'(mealy_a), 32'd0);
        drive(1'b1, 1'b1, 1'b0);
        chk("basic_b4_mealy", 32'(mealy_a), 32'd1);
        chk("basic_b4_moore", 32'(moore_a), 32'd0);
        chk("basic_b4_cnt", 32'(cnt_a), 32'd0);
        drive(1'b0, 1'b0, 1'b0);
        chk("basic_after_mealy", 32'(mealy_a), 32'd0);
        chk("basic_after_moore", 32'(moore_a), 32'd1);
        chk("basic_after_cnt", 32'(cnt_a), ecnt(1));
        drive(1'b0, 1'b0, 1'b0);
        chk("basic_after2_moore", 32'(moore_a), 32'd0);

        // Overlap vs non-overlap, stream 1101101 (MSB first)
        drive(1'b0, 1'b0, 1'b1);
        s_ov   = 7'b1101101;
        e_ov_a = 7'b0001001;
        e_ov_b = 7'b0001000;
        prev_a = 1'b0;
        prev_b = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            drive(s_ov[i], 1'b1, 1'b0);
            chk($sformatf("ovl_a_mealy_%0d", 7 - i), 32'(mealy_a), 32'(e_ov_a[i]));
            chk($sformatf("ovl_b_mealy_%0d", 7 - i), 32'(mealy_b), 32'(e_ov_b[i]));
            chk($sformatf("ovl_a_moore_%0d", 7 - i), 32'(moore_a), 32'(prev_a));
            chk($sformatf("ovl_b_moore_%0d", 7 - i), 32'(moore_b), 32'(prev_b));
            prev_a = e_ov_a[i];
            prev_b = e_ov_b[i];
        end
        drive(1'b0, 1'b0, 1'b0);
        chk("ovl_a_moore_end", 32'(moore_a), 32'd1);
        chk("ovl_b_moore_end", 32'(moore_b), 32'd0);
        chk("ovl_a_cnt", 32'(cnt_a), ecnt(2));
        chk("ovl_b_cnt", 32'(cnt_b), ecnt(1));

        // Enable gaps: 1,1, gap, gap, 0,1
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("gap1_moore", 32'(moore_a), 32'd0);
        chk("gap1_mealy", 32'(mealy_a), 32'd0);
        drive(1'b0, 1'b0, 1'b0);
        chk("gap2_moore", 32'(moore_a), 32'd0);
        drive(1'b0, 1'b1, 1'b0);
        chk("gap_b3_mealy", 32'(mealy_a), 32'd0);
        drive(1'b1, 1'b1, 1'b0);
        chk("gap_b4_mealy", 32'(mealy_a), 32'd1);
        drive(1'b0, 1'b0, 1'b0);
        chk("gap_moore", 32'(moore_a), 32'd1);
        chk("gap_cnt", 32'(cnt_a), ecnt(1));

        // Reset mid-sequence, then 1 -> no hit; then 1,1,0,1 -> hit
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        chk("rst_hit_mealy", 32'(mealy_a), 32'd0);
        drive(1'b1, 1'b1, 1'b0);
        chk("rst_post_moore", 32'(moore_a), 32'd0);
        chk("rst_post_cnt", 32'(cnt_a), 32'd0);
        chk("rst_post_mealy", 32'(mealy_a), 32'd0);
        drive(1'b1, 1'b1, 1'b0);  chk("rst_s2_mealy", 32'(mealy_a), 32'd0);
        drive(1'b1, 1'b1, 1'b0);  chk("rst_s3_mealy", 32'(mealy_a), 32'd0);
        drive(1'b0, 1'b1, 1'b0);  chk("rst_s4_mealy", 32'(mealy_a), 32'd0);
        drive(1'b1, 1'b1, 1'b0);  chk("rst_s5_mealy", 32'(mealy_a), 32'd1);
        drive(1'b0, 1'b0, 1'b0);
        chk("rst_cnt", 32'(cnt_a), ecnt(1));

        // Fill gating with all-zero pattern
        drive(1'b0, 1'b0, 1'b1);
        e_zero = 5'b00011;
        prev_c = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            drive(1'b0, 1'b1, 1'b0);
            chk($sformatf("zero_mealy_%0d", 5 - i), 32'(mealy_c), 32'(e_zero[i]));
            chk($sformatf("zero_moore_%0d", 5 - i), 32'(moore_c), 32'(prev_c));
            prev_c = e_zero[i];
        end
        drive(1'b1, 1'b0, 1'b0);
        chk("zero_moore_tail", 32'(moore_c), 32'd1);
        chk("zero_cnt", 32'(cnt_c), ecnt(2));
        drive(1'b1, 1'b0, 1'b0);
        chk("zero_moore_off", 32'(moore_c), 32'd0);

        // Counter saturation: five separate 1101 matches
        drive(1'b0, 1'b0, 1'b1);
        for (int m = 1; m <= 5; m++) begin
            drive(1'b1, 1'b1, 1'b0);
            drive(1'b1, 1'b1, 1'b0);
            drive(1'b0, 1'b1, 1'b0);
            drive(1'b1, 1'b1, 1'b0);
            chk($sformatf("sat_mealy_%0d", m), 32'(mealy_d), 32'd1);
            drive(1'b0, 1'b0, 1'b0);
            chk($sformatf("sat_moore_%0d", m), 32'(moore_d), 32'd1);
            chk($sformatf("sat_cnt_d_%0d", m), 32'(cnt_d), ecnt((m > 3) ? 3 : m));
            chk($sformatf("sat_cnt_a_%0d", m), 32'(cnt_a), ecnt(m));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
